// File: rtl/axis_pkt_checker_if.sv
// rtl/axis_pkt_checker_if.sv - AXI-Stream beat channel between packet source and checker
interface axis_pkt_checker_if;
   logic [31:0] tdata;
   logic [3:0]  tkeep;
   logic        tvalid;
   logic        tready;
   logic        tlast;

   modport master (output tdata, output tkeep, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tkeep, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pkt_checker.sv
// rtl/axis_pkt_checker.sv - checks incrementing-count packets of fixed length on an AXI-Stream sink
module axis_pkt_checker #(
   parameter int          PKT_LEN       = 11,
   parameter logic [15:0] READY_PATTERN = 16'hFFFF
) (
   input  logic                axis_aclk,
   input  logic                axis_aresetn,
   input  logic                check_en,
   input  logic                clear_stats,
   axis_pkt_checker_if.slave   axis,
   output logic                pkt_done,
   output logic                pkt_ok,
   output logic [15:0]         pkt_cnt,
   output logic [15:0]         err_cnt,
   output logic [2:0]          err_code,
   output logic                err_flag
);

   typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DRAIN} state_t;

   localparam logic [7:0] LEN     = 8'(PKT_LEN);
   localparam logic [2:0] E_NONE  = 3'd0;
   localparam logic [2:0] E_DATA  = 3'd1;
   localparam logic [2:0] E_KEEP  = 3'd2;
   localparam logic [2:0] E_EARLY = 3'd3;
   localparam logic [2:0] E_MISS  = 3'd4;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_pat;
   logic        r_tready;
   logic [7:0]  r_beat;
   logic [31:0] r_exp;
   logic [2:0]  r_code;
   logic        r_pkt_done;
   logic        r_pkt_ok;
   logic [15:0] r_pkt_cnt;
   logic [15:0] r_err_cnt;
   logic [2:0]  r_err_code;
   logic        r_err_flag;

   logic        w_accept;
   logic        w_end;
   logic [7:0]  w_beat_num;
   logic [31:0] w_exp_beat;
   logic [2:0]  w_beat_code;
   logic [2:0]  w_pkt_code;

   assign w_accept = axis.tvalid & r_tready;

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // r_code holds the first error seen so far in the packet; it is always E_NONE in IDLE.
   always_comb begin
      w_state_nxt = r_state;
      w_end       = 1'b0;
      w_beat_num  = r_beat + 8'd1;
      w_exp_beat  = r_exp + 32'd1;
      w_beat_code = E_NONE;
      w_pkt_code  = r_code;
      if (r_state == ST_IDLE) begin
         w_beat_num = 8'd1;
         w_exp_beat = 32'd1;
      end
      if (w_accept) begin
         case (r_state)
            ST_IDLE, ST_RECV: begin
               if (axis.tlast && (w_beat_num < LEN)) begin
                  w_beat_code = E_EARLY;
               end else if (!axis.tlast && (w_beat_num == LEN)) begin
                  w_beat_code = E_MISS;
               end else if (axis.tkeep != 4'hF) begin
                  w_beat_code = E_KEEP;
               end else if (axis.tdata != w_exp_beat) begin
                  w_beat_code = E_DATA;
               end
               if (r_code == E_NONE) begin
                  w_pkt_code = w_beat_code;
               end
               if (axis.tlast) begin
                  w_end       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (w_beat_num == LEN) begin
                  w_state_nxt = ST_DRAIN;
               end else begin
                  w_state_nxt = ST_RECV;
               end
            end
            ST_DRAIN: begin
               if (axis.tlast) begin
                  w_end       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (!axis_aresetn) begin
         r_pat      <= READY_PATTERN;
         r_tready   <= 1'b0;
         r_beat     <= 8'd0;
         r_exp      <= 32'd0;
         r_code     <= E_NONE;
         r_pkt_done <= 1'b0;
         r_pkt_ok   <= 1'b0;
         r_pkt_cnt  <= 16'd0;
         r_err_cnt  <= 16'd0;
         r_err_code <= E_NONE;
         r_err_flag <= 1'b0;
      end else begin
         r_tready <= check_en & r_pat[0];
         if (check_en) begin
            r_pat <= {r_pat[0], r_pat[15:1]};
         end
         r_pkt_done <= w_end;
         r_pkt_ok   <= w_end & (w_pkt_code == E_NONE);
         if (w_accept) begin
            if (w_end) begin
               r_beat <= 8'd0;
               r_exp  <= 32'd0;
               r_code <= E_NONE;
            end else if (r_state != ST_DRAIN) begin
               r_beat <= w_beat_num;
               r_exp  <= w_exp_beat;
               r_code <= w_pkt_code;
            end
         end
         // A clear in the same cycle as a packet end discards that packet's statistics.
         if (clear_stats) begin
            r_pkt_cnt  <= 16'd0;
            r_err_cnt  <= 16'd0;
            r_err_flag <= 1'b0;
         end else begin
            if (w_beat_code != E_NONE) begin
               r_err_flag <= 1'b1;
            end
            if (w_end) begin
               if (w_pkt_code == E_NONE) begin
                  r_pkt_cnt <= r_pkt_cnt + 16'd1;
               end else begin
                  if (r_err_cnt != 16'hFFFF) begin
                     r_err_cnt <= r_err_cnt + 16'd1;
                  end
                  r_err_code <= w_pkt_code;
               end
            end
         end
      end
   end

   assign axis.tready = r_tready;
   assign pkt_done    = r_pkt_done;
   assign pkt_ok      = r_pkt_ok;
   assign pkt_cnt     = r_pkt_cnt;
   assign err_cnt     = r_err_cnt;
   assign err_code    = r_err_code;
   assign err_flag    = r_err_flag;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// tb/tb_axis_pkt_checker.sv - randomized self-checking bench for axis_pkt_checker
module tb_axis_pkt_checker;
   localparam int          L   = 11;
   localparam logic [15:0] PAT = 16'h00FF;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        check_en = 1'b0;
   logic        clear_stats = 1'b0;
   logic        pkt_done, pkt_ok, err_flag;
   logic [15:0] pkt_cnt, err_cnt;
   logic [2:0]  err_code;

   axis_pkt_checker_if axis_if ();

   axis_pkt_checker #(.PKT_LEN(L), .READY_PATTERN(PAT)) dut (
      .axis_aclk   (aclk),
      .axis_aresetn(aresetn),
      .check_en    (check_en),
      .clear_stats (clear_stats),
      .axis        (axis_if),
      .pkt_done    (pkt_done),
      .pkt_ok      (pkt_ok),
      .pkt_cnt     (pkt_cnt),
      .err_cnt     (err_cnt),
      .err_code    (err_code),
      .err_flag    (err_flag)
   );

   always #5 aclk = ~aclk;

   int vectors = 0;
   int miscompares = 0;

   int   done_cnt = 0;
   logic last_ok = 1'b0;
   always @(negedge aclk) begin
      if (pkt_done === 1'b1) begin
         done_cnt++;
         last_ok = pkt_ok;
      end
   end

   // Reference statistics, updated once per whole packet.
   int m_pkt = 0;
   int m_err = 0;
   int m_code = 0;
   bit m_flag = 1'b0;

   logic [31:0] b_data [64];
   logic [3:0]  b_keep [64];
   bit          b_last [64];
   int          b_n;

   // Source sends a counting packet of n beats with tlast only on the final beat.
   function automatic int model_code();
      int first = 0;
      for (int i = 0; i < b_n; i++) begin
         int pos = i + 1;
         int c = 0;
         if (pos <= L) begin
            if (b_last[i] && pos < L)        c = 3;
            else if (!b_last[i] && pos == L) c = 4;
            else if (b_keep[i] != 4'hF)      c = 2;
            else if (b_data[i] != 32'(pos))  c = 1;
         end
         if (first == 0) first = c;
      end
      return first;
   endfunction

   task automatic build_pkt(input int n, input int err_pos, input int err_kind);
      b_n = n;
      for (int i = 0; i < n; i++) begin
         b_data[i] = 32'(i + 1);
         b_keep[i] = 4'hF;
         b_last[i] = (i == n - 1);
      end
      if (err_kind == 1) b_data[err_pos-1] = 32'(err_pos) ^ (32'd1 << $urandom_range(31, 0));
      if (err_kind == 2) b_keep[err_pos-1] = 4'hF ^ 4'($urandom_range(15, 1));
   endtask

   task automatic put_beat(input int i, input bit clr_last);
      bit got = 1'b0;
      axis_if.tdata  = b_data[i];
      axis_if.tkeep  = b_keep[i];
      axis_if.tlast  = b_last[i];
      axis_if.tvalid = 1'b1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         got = axis_if.tready;
         if (got && clr_last && b_last[i]) clear_stats = 1'b1;
         @(posedge aclk);
         #1;
         clear_stats = 1'b0;
         if (got) break;
      end
      if (!got) begin
         vectors++;
         miscompares++;
         $display("FAIL beat_timeout: beat %0d not accepted within 300 cycles", i + 1);
      end
   endtask

   task automatic idle_gap();
      axis_if.tvalid = 1'b0;
      repeat ($urandom_range(2, 0)) @(posedge aclk);
      #1;
   endtask

   task automatic model_update(input int code, input bit clr);
      if (clr) begin
         m_pkt = 0; m_err = 0; m_flag = 1'b0;
      end else if (code == 0) begin
         m_pkt = (m_pkt + 1) & 16'hFFFF;
      end else begin
         if (m_err < 16'hFFFF) m_err++;
         m_code = code;
         m_flag = 1'b1;
      end
   endtask

   task automatic settle();
      axis_if.tvalid = 1'b0;
      @(negedge aclk);
      @(negedge aclk);
      #1;
   endtask

   task automatic send_pkt(input bit clr_last, input bit gaps, output bit exp_ok);
      int code;
      for (int i = 0; i < b_n; i++) begin
         if (gaps && $urandom_range(3, 0) == 0) idle_gap();
         put_beat(i, clr_last);
      end
      code = model_code();
      exp_ok = (code == 0);
      model_update(code, clr_last);
      settle();
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      check_en = 1'b0;
      axis_if.tvalid = 1'b0; axis_if.tdata = '0; axis_if.tkeep = '0; axis_if.tlast = 1'b0;
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      vectors++; if (axis_if.tready !== 1'b0) begin miscompares++; $display("FAIL reset_tready: got %b want 0", axis_if.tready); end
      vectors++; if (pkt_done !== 1'b0) begin miscompares++; $display("FAIL reset_pkt_done: got %b want 0", pkt_done); end
      vectors++; if (pkt_ok !== 1'b0) begin miscompares++; $display("FAIL reset_pkt_ok: got %b want 0", pkt_ok); end
      vectors++; if (pkt_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
      vectors++; if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
      vectors++; if (err_code !== 3'd0) begin miscompares++; $display("FAIL reset_err_code: got %0d want 0", err_code); end
      vectors++; if (err_flag !== 1'b0) begin miscompares++; $display("FAIL reset_err_flag: got %b want 0", err_flag); end
   endtask

   task automatic test_ready_pattern();
      logic [15:0] p = PAT;
      axis_if.tvalid = 1'b1;
      axis_if.tdata = 32'd1; axis_if.tkeep = 4'hF; axis_if.tlast = 1'b0;
      axis_if.tvalid = 1'b0;
      check_en = 1'b1;
      for (int k = 0; k < 32; k++) begin
         @(posedge aclk);
         #1;
         vectors++;
         if (axis_if.tready !== p[k%16]) begin
            miscompares++;
            $display("FAIL ready_pattern[%0d]: got %b want %b", k, axis_if.tready, p[k%16]);
         end
      end
      check_en = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      vectors++; if (axis_if.tready !== 1'b0) begin miscompares++; $display("FAIL ready_disabled: got %b want 0", axis_if.tready); end
      check_en = 1'b1;
   endtask

   task automatic test_good();
      bit ok;
      int d0 = done_cnt;
      build_pkt(L, 1, 0);
      send_pkt(1'b0, 1'b0, ok);
      vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL good_done_pulses: got %0d want 1", done_cnt - d0); end
      vectors++; if (last_ok !== 1'b1) begin miscompares++; $display("FAIL good_pkt_ok: got %b want 1", last_ok); end
      vectors++; if (pkt_cnt !== 16'(m_pkt)) begin miscompares++; $display("FAIL good_pkt_cnt: got %0d want %0d", pkt_cnt, m_pkt); end
      vectors++; if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL good_err_cnt: got %0d want 0", err_cnt); end
      vectors++; if (err_code !== 3'd0) begin miscompares++; $display("FAIL good_err_code: got %0d want 0", err_code); end
   endtask

   task automatic test_data_err();
      bit ok;
      int d0 = done_cnt;
      build_pkt(L, 5, 0);
      b_data[4] = 32'd9;
      send_pkt(1'b0, 1'b1, ok);
      vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL data_done_pulses: got %0d want 1", done_cnt - d0); end
      vectors++; if (last_ok !== 1'b0) begin miscompares++; $display("FAIL data_pkt_ok: got %b want 0", last_ok); end
      vectors++; if (err_code !== 3'd1) begin miscompares++; $display("FAIL data_err_code: got %0d want 1", err_code); end
      vectors++; if (err_cnt !== 16'(m_err)) begin miscompares++; $display("FAIL data_err_cnt: got %0d want %0d", err_cnt, m_err); end
      vectors++; if (pkt_cnt !== 16'(m_pkt)) begin miscompares++; $display("FAIL data_pkt_cnt: got %0d want %0d", pkt_cnt, m_pkt); end
      vectors++; if (err_flag !== 1'b1) begin miscompares++; $display("FAIL data_err_flag: got %b want 1", err_flag); end
   endtask

   task automatic test_early_tlast();
      bit ok;
      int d0 = done_cnt;
      build_pkt(7, 1, 0);
      send_pkt(1'b0, 1'b0, ok);
      vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL early_done_pulses: got %0d want 1", done_cnt - d0); end
      vectors++; if (err_code !== 3'd3) begin miscompares++; $display("FAIL early_err_code: got %0d want 3", err_code); end
      build_pkt(L, 1, 0);
      send_pkt(1'b0, 1'b1, ok);
      vectors++; if (last_ok !== 1'b1) begin miscompares++; $display("FAIL early_next_ok: got %b want 1", last_ok); end
      vectors++; if (pkt_cnt !== 16'(m_pkt)) begin miscompares++; $display("FAIL early_next_pkt_cnt: got %0d want %0d", pkt_cnt, m_pkt); end
   endtask

   task automatic test_missing_tlast();
      bit ok;
      int d0 = done_cnt;
      build_pkt(14, 1, 0);
      b_data[12] = 32'hDEAD_BEEF;
      b_keep[13] = 4'h3;
      send_pkt(1'b0, 1'b1, ok);
      vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL drain_done_pulses: got %0d want 1", done_cnt - d0); end
      vectors++; if (last_ok !== 1'b0) begin miscompares++; $display("FAIL drain_pkt_ok: got %b want 0", last_ok); end
      vectors++; if (err_code !== 3'd4) begin miscompares++; $display("FAIL drain_err_code: got %0d want 4", err_code); end
      vectors++; if (err_cnt !== 16'(m_err)) begin miscompares++; $display("FAIL drain_err_cnt: got %0d want %0d", err_cnt, m_err); end
   endtask

   task automatic test_stall();
      int d0 = done_cnt;
      build_pkt(L, 1, 0);
      for (int i = 0; i < 5; i++) put_beat(i, 1'b0);
      axis_if.tvalid = 1'b0;
      check_en = 1'b0;
      @(posedge aclk);
      #1;
      axis_if.tdata = b_data[5]; axis_if.tkeep = b_keep[5]; axis_if.tlast = b_last[5];
      axis_if.tvalid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         vectors++;
         if (axis_if.tready !== 1'b0) begin miscompares++; $display("FAIL stall_tready[%0d]: got %b want 0", k, axis_if.tready); end
         @(posedge aclk);
         #1;
      end
      check_en = 1'b1;
      for (int i = 5; i < b_n; i++) put_beat(i, 1'b0);
      model_update(model_code(), 1'b0);
      settle();
      vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL stall_done_pulses: got %0d want 1", done_cnt - d0); end
      vectors++; if (last_ok !== 1'b1) begin miscompares++; $display("FAIL stall_pkt_ok: got %b want 1", last_ok); end
      vectors++; if (pkt_cnt !== 16'(m_pkt)) begin miscompares++; $display("FAIL stall_pkt_cnt: got %0d want %0d", pkt_cnt, m_pkt); end
   endtask

   task automatic test_clear_coincident();
      bit ok;
      int d0;
      build_pkt(L, 3, 2);
      send_pkt(1'b0, 1'b0, ok);
      d0 = done_cnt;
      build_pkt(L, 1, 0);
      send_pkt(1'b1, 1'b1, ok);
      vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL clr_done_pulses: got %0d want 1", done_cnt - d0); end
      vectors++; if (pkt_cnt !== 16'd0) begin miscompares++; $display("FAIL clr_pkt_cnt: got %0d want 0", pkt_cnt); end
      vectors++; if (err_cnt !== 16'd0) begin miscompares++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
      vectors++; if (err_flag !== 1'b0) begin miscompares++; $display("FAIL clr_err_flag: got %b want 0", err_flag); end
      vectors++; if (err_code !== 3'(m_code)) begin miscompares++; $display("FAIL clr_err_code: got %0d want %0d", err_code, m_code); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int d0;
      for (int p = 0; p < 5; p++) begin
         build_pkt(L, 1, 0);
         send_pkt(1'b0, 1'b0, ok);
      end
      vectors++; if (pkt_cnt !== 16'(m_pkt)) begin miscompares++; $display("FAIL rst_pre_pkt_cnt: got %0d want %0d", pkt_cnt, m_pkt); end
      build_pkt(L, 1, 0);
      for (int i = 0; i < 4; i++) put_beat(i, 1'b0);
      axis_if.tvalid = 1'b0;
      d0 = done_cnt;
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      m_pkt = 0; m_err = 0; m_code = 0; m_flag = 1'b0;
      vectors++; if (axis_if.tready !== 1'b0) begin miscompares++; $display("FAIL rst_mid_tready: got %b want 0", axis_if.tready); end
      vectors++; if (pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin miscompares++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", pkt_cnt, err_cnt); end
      vectors++; if (err_code !== 3'd0 || err_flag !== 1'b0) begin miscompares++; $display("FAIL rst_mid_err: got %0d/%b want 0/0", err_code, err_flag); end
      clear_stats = 1'b1;
      @(posedge aclk);
      #1;
      clear_stats = 1'b0;
      settle();
      vectors++; if (done_cnt !== d0) begin miscompares++; $display("FAIL rst_mid_no_done: got %0d want %0d", done_cnt, d0); end
      build_pkt(L, 1, 0);
      send_pkt(1'b0, 1'b1, ok);
      vectors++; if (last_ok !== 1'b1) begin miscompares++; $display("FAIL rst_next_ok: got %b want 1", last_ok); end
      vectors++; if (pkt_cnt !== 16'd1) begin miscompares++; $display("FAIL rst_next_pkt_cnt: got %0d want 1", pkt_cnt); end
   endtask

   task automatic test_random();
      bit ok;
      int d0;
      for (int p = 0; p < 24; p++) begin
         int n = $urandom_range(L + 3, L - 3);
         build_pkt(n, $urandom_range(n, 1), $urandom_range(3, 0));
         d0 = done_cnt;
         send_pkt(1'b0, 1'b1, ok);
         vectors++; if (done_cnt - d0 !== 1) begin miscompares++; $display("FAIL rnd%0d_done_pulses: got %0d want 1", p, done_cnt - d0); end
         vectors++; if (last_ok !== ok) begin miscompares++; $display("FAIL rnd%0d_pkt_ok: got %b want %b", p, last_ok, ok); end
         vectors++; if (pkt_cnt !== 16'(m_pkt)) begin miscompares++; $display("FAIL rnd%0d_pkt_cnt: got %0d want %0d", p, pkt_cnt, m_pkt); end
         vectors++; if (err_cnt !== 16'(m_err)) begin miscompares++; $display("FAIL rnd%0d_err_cnt: got %0d want %0d", p, err_cnt, m_err); end
         vectors++; if (err_code !== 3'(m_code)) begin miscompares++; $display("FAIL rnd%0d_err_code: got %0d want %0d", p, err_code, m_code); end
         vectors++; if (err_flag !== m_flag) begin miscompares++; $display("FAIL rnd%0d_err_flag: got %b want %b", p, err_flag, m_flag); end
      end
   endtask

   initial begin
      test_reset();
      test_ready_pattern();
      test_good();
      test_data_err();
      test_early_tlast();
      test_missing_tlast();
      test_stall();
      test_clear_coincident();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
